// File: rtl/hpi_pkg.sv
// Shared definitions for the EZ-OTG (CY7C67200) HPI bridge.
//   hpi_state_t   : bridge FSM states
//   HPI_*         : HPI register indices as seen on otg_addr
//   DEF_*_CYC     : default bus-cycle timing, in clk cycles
//   max2()        : helper for sizing the shared timing counter
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4,
    ST_RECOVER = 3'd5
  } hpi_state_t;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  localparam int unsigned DEF_SETUP_CYC   = 1;
  localparam int unsigned DEF_STROBE_CYC  = 4;
  localparam int unsigned DEF_HOLD_CYC    = 1;
  localparam int unsigned DEF_RECOVER_CYC = 2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/otg_hpi_bridge.sv
// Avalon-MM slave that turns each read or write into one timed HPI bus
// cycle on the CY7C67200 pins.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   address[1:0]        HPI register select (DATA/MAILBOX/ADDRESS/STATUS)
//   chipselect, read,   Avalon request; read+write together is a write
//   write, writedata
//   readdata[15:0]      registered read data, valid in DONE
//   waitrequest         combinational stall, low only in DONE
//   otg_addr, otg_cs_n, HPI address, chip select and strobes (registered)
//   otg_rd_n, otg_wr_n
//   otg_data_out/_oe    drive side of the bidirectional data pad
//   otg_data_in         receive side of the data pad
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | bus inactive, waiting for a request
// SETUP   | cs_n low, address (and write data) settling before strobe
// STROBE  | rd_n or wr_n low; read data captured on the last cycle
// HOLD    | strobe released, cs_n/address/data still held
// DONE    | one cycle, waitrequest released to complete the handshake
// RECOVER | bus idle gap before the next cycle may start
module otg_hpi_bridge
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC  = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned RECOVER_CYC = DEF_RECOVER_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in
);

  localparam int unsigned MAX_CYC = max2(max2(SETUP_CYC, STROBE_CYC),
                                         max2(HOLD_CYC, RECOVER_CYC));
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

  hpi_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             is_wr;
  logic             req;
  logic             cnt_zero;

  assign req         = chipselect & (read | write);
  assign waitrequest = req & (state != ST_DONE);
  assign cnt_zero    = (cnt == '0);

  // otg_addr and otg_data_out double as the latched request: they are
  // loaded only when leaving IDLE, so they cannot move mid-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      is_wr        <= 1'b0;
      readdata     <= '0;
      otg_addr     <= '0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_data_out <= '0;
      otg_data_oe  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            is_wr        <= write;
            otg_addr     <= address;
            otg_data_out <= writedata;
            otg_data_oe  <= write;
            otg_cs_n     <= 1'b0;
            cnt          <= SETUP_LD;
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            otg_rd_n <= is_wr;
            otg_wr_n <= ~is_wr;
            cnt      <= STROBE_LD;
            state    <= ST_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt_zero) begin
            if (!is_wr) begin
              readdata <= otg_data_in;
            end
            otg_rd_n <= 1'b1;
            otg_wr_n <= 1'b1;
            cnt      <= HOLD_LD;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            otg_cs_n    <= 1'b1;
            otg_data_oe <= 1'b0;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          // Runs to RECOVER whether or not the master is still waiting;
          // a dropped request simply skips the handshake.
          cnt   <= RECOVER_LD;
          state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (cnt_zero) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          otg_cs_n    <= 1'b1;
          otg_rd_n    <= 1'b1;
          otg_wr_n    <= 1'b1;
          otg_data_oe <= 1'b0;
          cnt         <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otg_hpi_bridge.sv
// Self-checking bench for otg_hpi_bridge with default timing.
// Write transactions are scored on the pins at each wr_n falling edge;
// read transactions are scored at the Avalon handshake.
module tb_otg_hpi_bridge;
  import hpi_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        waitrequest;
  logic [1:0]  otg_addr;
  logic        otg_cs_n;
  logic        otg_rd_n;
  logic        otg_wr_n;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in;

  logic [15:0] pad_val;
  int          cyc;
  int          n_tests;
  int          n_fail;
  logic [17:0] wr_q[$];
  logic [15:0] rd_q[$];
  int          fall_q[$];
  logic        prev_wr_n;

  otg_hpi_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .waitrequest  (waitrequest),
    .otg_addr     (otg_addr),
    .otg_cs_n     (otg_cs_n),
    .otg_rd_n     (otg_rd_n),
    .otg_wr_n     (otg_wr_n),
    .otg_data_out (otg_data_out),
    .otg_data_oe  (otg_data_oe),
    .otg_data_in  (otg_data_in)
  );

  // Pad model: the chip drives its data only while rd_n is low.
  assign otg_data_in = otg_rd_n ? 16'h0000 : pad_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: address/data/oe must be on the pins when wr_n falls.
  always @(negedge clk) begin
    if (!reset && prev_wr_n === 1'b1 && otg_wr_n === 1'b0) begin
      fall_q.push_back(cyc);
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        logic [17:0] e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(otg_addr), 32'(e[17:16]));
        check("wr_data", 32'(otg_data_out), 32'(e[15:0]));
        check("wr_oe", 32'(otg_data_oe), 32'd1);
      end
    end
    prev_wr_n <= otg_wr_n;
  end

  task automatic drop_req();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  // Issues one request in the current cycle (t0) and checks the pins for
  // cycles t0+1..t0+10. drop_k>0 drops the request at t0+drop_k; chain
  // keeps it held through RECOVER so the next call starts at t0+10.
  task automatic txn(input logic [1:0] a, input logic [15:0] wd, input bit rd,
                     input bit wr, input int drop_k, input bit chain);
    bit req_on;
    bit in_strobe;
    bit in_cs;
    req_on     = 1'b1;
    address    = a;
    writedata  = wd;
    read       = rd;
    write      = wr;
    chipselect = 1'b1;
    if (wr) wr_q.push_back({a, wd});
    else if (rd) rd_q.push_back(pad_val);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == drop_k || (k == 8 && !chain)) begin
        drop_req();
        req_on = 1'b0;
      end
      #1;
      in_cs     = (k >= 1 && k <= 6);
      in_strobe = (k >= 2 && k <= 5);
      check($sformatf("cs_n k=%0d", k), 32'(otg_cs_n), 32'(!in_cs));
      check($sformatf("wr_n k=%0d", k), 32'(otg_wr_n), 32'(!(wr && in_strobe)));
      check($sformatf("rd_n k=%0d", k), 32'(otg_rd_n), 32'(!(!wr && in_strobe)));
      check($sformatf("oe k=%0d", k), 32'(otg_data_oe), 32'(wr && in_cs));
      check($sformatf("waitreq k=%0d", k), 32'(waitrequest), 32'(req_on && k != 7));
      if (k == 1) check("otg_addr", 32'(otg_addr), 32'(a));
      if (k == 7 && rd && !wr) begin
        if (rd_q.size() == 0) check("rd_underflow", 32'd1, 32'd0);
        else check("readdata", 32'(readdata), 32'(rd_q.pop_front()));
      end
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    prev_wr_n  = 1'b1;
    pad_val    = 16'h0000;
    reset      = 1'b1;
    address    = '0;
    writedata  = '0;
    drop_req();

    repeat (3) @(negedge clk);
    #1;
    check("rst cs_n", 32'(otg_cs_n), 32'd1);
    check("rst rd_n", 32'(otg_rd_n), 32'd1);
    check("rst wr_n", 32'(otg_wr_n), 32'd1);
    check("rst oe", 32'(otg_data_oe), 32'd0);
    check("rst waitreq", 32'(waitrequest), 32'd0);
    check("rst readdata", 32'(readdata), 32'd0);
    check("rst addr", 32'(otg_addr), 32'd0);
    check("rst data_out", 32'(otg_data_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Single write, then single read of DATA.
    txn(HPI_ADDRESS, 16'h1000, 1'b0, 1'b1, 0, 1'b0);
    pad_val = 16'hBEEF;
    txn(HPI_DATA, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

    // Back-to-back writes with the request held across RECOVER.
    fall_q.delete();
    txn(HPI_MAILBOX, 16'hA5A5, 1'b0, 1'b1, 0, 1'b1);
    txn(HPI_DATA, 16'h5A5A, 1'b0, 1'b1, 0, 1'b0);
    if (fall_q.size() != 2) check("b2b falls", 32'(fall_q.size()), 32'd2);
    else check("b2b spacing", 32'(fall_q[1] - fall_q[0]), 32'd10);

    // STATUS is a plain read.
    pad_val = 16'h0042;
    txn(HPI_STATUS, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

    // read+write together is a write; request abandoned at t0+3.
    txn(HPI_ADDRESS, 16'h1234, 1'b1, 1'b1, 3, 1'b0);
    // Starts at the old t0+10, so its timing shows the FSM was back in IDLE.
    pad_val = 16'hCAFE;
    txn(HPI_DATA, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

    // Reset in the middle of a write strobe.
    address    = HPI_MAILBOX;
    writedata  = 16'h7777;
    write      = 1'b1;
    read       = 1'b0;
    chipselect = 1'b1;
    wr_q.push_back({HPI_MAILBOX, 16'h7777});
    repeat (3) @(negedge clk);
    #1;
    check("pre-rst wr_n", 32'(otg_wr_n), 32'd0);
    check("pre-rst cs_n", 32'(otg_cs_n), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("async rst wr_n", 32'(otg_wr_n), 32'd1);
    check("async rst cs_n", 32'(otg_cs_n), 32'd1);
    check("async rst oe", 32'(otg_data_oe), 32'd0);
    check("async rst rd_n", 32'(otg_rd_n), 32'd1);
    drop_req();
    @(negedge clk);
    reset = 1'b0;
    #1;
    pad_val = 16'h1357;
    txn(HPI_DATA, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

    check("wr_q empty", 32'(wr_q.size()), 32'd0);
    check("rd_q empty", 32'(rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
